rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares the single-port, synchronous-read 32 KB boot ROM between two requesters: the Z80 CPU path (`cpu_*`) and an auxiliary reader (`aux_*`, e.g. boot copy or debug). It sits between the memory-map decoder and the ROM instance. It drives the ROM address from a registered grant and returns read data to the winning port with a one-cycle acknowledge pulse. It is fully pipelined: one ROM access can be issued every clock.

## Interface
- `AW`, default 15: ROM address width.
- `DW`, default 8: data width.
- `STARVE_MAX`, default 4: number of consecutive denied aux cycles before aux is forced to win.
- `clk`  in  1: system clock, the only clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cpu_req`  in  1: CPU read request, level.
- `cpu_addr`  in  AW: CPU address, stable while `cpu_req` is high and unacknowledged.
- `cpu_ack`  out  1: one-cycle pulse; `cpu_data` is valid in this cycle.
- `cpu_data`  out  DW: registered read data, held until the next CPU ack.
- `aux_req`, `aux_addr`, `aux_ack`, `aux_data`: same definitions as the CPU port, for the aux port.
- `rom_a`  out  AW: registered ROM address.
- `rom_dout`  in  DW: ROM data; valid one clock after `rom_a` is sampled.

## Operation
- Per-port `busy` flag: set on grant, cleared on ack. `req` is ignored while the port is busy, so a held request is never reissued.
- Grant is evaluated each cycle over eligible ports, i.e. `req & ~busy`:
  - Only one port eligible: that port wins.
  - Both eligible: CPU wins, unless `starve_cnt == STARVE_MAX`, in which case aux wins.
- `starve_cnt`:
  - Increments when aux is eligible and loses.
  - Clears to 0 when aux wins or aux is not eligible.
  - Saturates at `STARVE_MAX`.
- Pipeline stages, each carrying a valid bit and a tag (CPU or AUX):
  - S0 grant: `rom_a <= winner addr`; S1 valid with the winner's tag.
  - S1 → S2: the ROM samples `rom_a`.
  - S2: `<port>_data <= rom_dout`; `<port>_ack <= 1` for exactly one cycle.
- With no grant, `rom_a` holds its last value and S1 is invalid.
- A port may assert `req` with a new address in its ack cycle. It is eligible in that cycle because `busy` clears as the ack is issued, combinationally for eligibility.
- Reset mid-operation: all in-flight accesses are discarded, no ack is produced for them, and `busy` is cleared.

## Timing
- Reset values: `cpu_ack=0`, `aux_ack=0`, `cpu_data=0`, `aux_data=0`, `rom_a=0`, both `busy=0`, `starve_cnt=0`, all pipeline valid bits 0.
- Latency: request seen at edge N → `rom_a` updated at N+1 → ROM data registered at N+2 → ack and data visible after edge N+3. That is 3 clocks, fixed, for both ports.
- Throughput: one grant per clock. Back-to-back grants alternate freely between ports. Both ports can be outstanding at once.
- Simultaneous first requests from both ports: CPU is acknowledged at N+3, aux is acknowledged at N+4.
- An address change while busy is a requester protocol violation. The address captured at grant is the one that is read.

## Configuration
- `ROM_ARB_RR_EN` defined: fixed CPU priority is replaced by round-robin.
  - A `last_grant` register, reset to AUX so the CPU wins the first tie, gives the tie to the port not granted last.
  - The starvation counter and `STARVE_MAX` are not instantiated.
- `ROM_ARB_RR_EN` undefined: CPU priority with the starvation override, as described above.

## Structure
- Package `rom_arb_pkg`:
  - Port tag type with values `TAG_CPU` and `TAG_AUX`.
  - Constant `ROM_ARB_LAT = 3`.
  - Default `AW` and `DW`.
- Sub-module `rom_arb_grant`: combinational winner selection plus the `starve_cnt`/`last_grant` register. The pipeline, `busy` flags and output registers stay in `rom_arbiter`.

## Test plan
- After reset, hold both req low for 5 cycles → both acks 0, both data 0, `rom_a=0`.
- CPU only: `cpu_req=1`, `cpu_addr=0x0007`, ROM model holds `mem[7]=0xED` → `rom_a=0x0007` after 1 clock; `cpu_ack` pulses 3 clocks after the request with `cpu_data=0xED`; no second ack while req stays high until the ack.
- Both request in the same cycle (CPU 0x0000, aux 0x0001; `mem[0]=0x21`, `mem[1]=0x0E`) → `cpu_ack` with 0x21 at +3, `aux_ack` with 0x0E at +4.
- CPU streams a new address every ack cycle while aux is held requesting → aux wins no later than its 5th eligible cycle (`STARVE_MAX=4`); with `ROM_ARB_RR_EN`, grants alternate CPU/aux.
- `rst_n` is low for one cycle while two accesses are in flight → no ack is ever produced for them; a fresh request afterwards acks after 3 clocks.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// +----------------------------------------------------------------------+
// | rom_arb_pkg                                                          |
// | Shared types and constants for the boot ROM arbiter.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package rom_arb_pkg;

   // Owner of an in-flight ROM access
   typedef enum logic {
      TAG_CPU = 1'b0,
      TAG_AUX = 1'b1
   } tag_t;

   // Request-to-acknowledge latency in clocks, fixed for both ports
   localparam int ROM_ARB_LAT = 3;

   // Default geometry: 32 KB x 8 boot ROM
   localparam int ROM_ARB_AW = 15;
   localparam int ROM_ARB_DW = 8;

endpackage

`default_nettype wire

// File: rtl/rom_arb_if.sv
// +----------------------------------------------------------------------+
// | rom_arb_if                                                           |
// | Requester and ROM-side signals of the boot ROM arbiter.              |
// | master: requesters plus ROM instance; slave: the arbiter itself.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface rom_arb_if
   import rom_arb_pkg::*;
#(
   parameter int AW = ROM_ARB_AW,
   parameter int DW = ROM_ARB_DW
) ();

   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_ack;
   logic [DW-1:0] cpu_data;

   logic          aux_req;
   logic [AW-1:0] aux_addr;
   logic          aux_ack;
   logic [DW-1:0] aux_data;

   logic [AW-1:0] rom_a;
   logic [DW-1:0] rom_dout;

   modport master (
      output cpu_req, cpu_addr, aux_req, aux_addr, rom_dout,
      input  cpu_ack, cpu_data, aux_ack, aux_data, rom_a
   );

   modport slave (
      input  cpu_req, cpu_addr, aux_req, aux_addr, rom_dout,
      output cpu_ack, cpu_data, aux_ack, aux_data, rom_a
   );

endinterface

`default_nettype wire

// File: rtl/rom_arb_grant.sv
// +----------------------------------------------------------------------+
// | rom_arb_grant                                                        |
// | Winner selection between the CPU and aux ports.                      |
// | Default: CPU priority with an aux starvation override.               |
// | ROM_ARB_RR_EN defined: round-robin tie break on last_grant instead.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rom_arb_grant
   import rom_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_cpu_elig,
   input  wire logic i_aux_elig,
   output logic      o_gnt_cpu,
   output logic      o_gnt_aux
);

`ifdef ROM_ARB_RR_EN

   tag_t r_last_grant;

   // Tie goes to the port that was not granted last
   always_comb begin
      o_gnt_cpu = 1'b0;
      o_gnt_aux = 1'b0;
      if (i_cpu_elig && i_aux_elig) begin
         if (r_last_grant == TAG_AUX) o_gnt_cpu = 1'b1;
         else                         o_gnt_aux = 1'b1;
      end else begin
         o_gnt_cpu = i_cpu_elig;
         o_gnt_aux = i_aux_elig;
      end
   end

   // Remember the most recent winner; reset to AUX so CPU takes the first tie
   always_ff @(posedge clk) begin
      if (!rst_n)         r_last_grant <= TAG_AUX;
      else if (o_gnt_cpu) r_last_grant <= TAG_CPU;
      else if (o_gnt_aux) r_last_grant <= TAG_AUX;
   end

`else

   localparam int              c_CW         = $clog2(STARVE_MAX + 1);
   localparam logic [c_CW-1:0] c_STARVE_MAX = c_CW'(STARVE_MAX);

   logic [c_CW-1:0] r_starve_cnt;

   // CPU wins ties unless aux has been denied STARVE_MAX times in a row
   always_comb begin
      o_gnt_cpu = 1'b0;
      o_gnt_aux = 1'b0;
      if (i_cpu_elig && i_aux_elig) begin
         if (r_starve_cnt == c_STARVE_MAX) o_gnt_aux = 1'b1;
         else                              o_gnt_cpu = 1'b1;
      end else begin
         o_gnt_cpu = i_cpu_elig;
         o_gnt_aux = i_aux_elig;
      end
   end

   // Count consecutive aux denials, saturating; any other outcome clears it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (i_aux_elig && !o_gnt_aux) begin
         if (r_starve_cnt != c_STARVE_MAX) r_starve_cnt <= r_starve_cnt + c_CW'(1);
      end else begin
         r_starve_cnt <= '0;
      end
   end

`endif

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// +----------------------------------------------------------------------+
// | rom_arbiter                                                          |
// | Shares the synchronous-read boot ROM between the CPU and an aux      |
// | reader. Fully pipelined, fixed 3-clock request-to-ack latency.       |
// | Optional macro ROM_ARB_RR_EN: round-robin instead of CPU priority.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int AW         = ROM_ARB_AW,
   parameter int DW         = ROM_ARB_DW,
   parameter int STARVE_MAX = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   rom_arb_if.slave  bus
);

   // Stages after the grant: S1 (address at ROM) and S2 (ROM data out)
   localparam int c_DEPTH = ROM_ARB_LAT - 1;
   localparam int c_LAST  = c_DEPTH - 1;

   logic                r_cpu_busy;
   logic                r_aux_busy;
   logic                r_cpu_ack;
   logic                r_aux_ack;
   logic [DW-1:0]       r_cpu_data;
   logic [DW-1:0]       r_aux_data;
   logic [AW-1:0]       r_rom_a;
   logic [c_DEPTH-1:0]  r_vld;
   tag_t                r_tag [c_DEPTH];

   logic                w_cpu_elig;
   logic                w_aux_elig;
   logic                w_gnt_cpu;
   logic                w_gnt_aux;

   // A port is eligible in its ack cycle, so a new request can follow the ack directly
   always_comb begin
      w_cpu_elig = bus.cpu_req & (~r_cpu_busy | r_cpu_ack);
      w_aux_elig = bus.aux_req & (~r_aux_busy | r_aux_ack);
   end

   rom_arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cpu_elig (w_cpu_elig),
      .i_aux_elig (w_aux_elig),
      .o_gnt_cpu  (w_gnt_cpu),
      .o_gnt_aux  (w_gnt_aux)
   );

   // Grant stage drives the ROM address; valid/tag then ride alongside the ROM read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rom_a <= '0;
         r_vld   <= '0;
         for (int i = 0; i < c_DEPTH; i++) r_tag[i] <= TAG_CPU;
      end else begin
         if (w_gnt_cpu)      r_rom_a <= bus.cpu_addr;
         else if (w_gnt_aux) r_rom_a <= bus.aux_addr;
         r_vld[0] <= w_gnt_cpu | w_gnt_aux;
         r_tag[0] <= w_gnt_aux ? TAG_AUX : TAG_CPU;
         for (int i = 1; i < c_DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Final stage: capture ROM data for the owning port and pulse its ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cpu_ack  <= 1'b0;
         r_aux_ack  <= 1'b0;
         r_cpu_data <= '0;
         r_aux_data <= '0;
      end else begin
         r_cpu_ack <= r_vld[c_LAST] && (r_tag[c_LAST] == TAG_CPU);
         r_aux_ack <= r_vld[c_LAST] && (r_tag[c_LAST] == TAG_AUX);
         if (r_vld[c_LAST] && (r_tag[c_LAST] == TAG_CPU)) r_cpu_data <= bus.rom_dout;
         if (r_vld[c_LAST] && (r_tag[c_LAST] == TAG_AUX)) r_aux_data <= bus.rom_dout;
      end
   end

   // Busy from grant until ack; a grant in the ack cycle keeps the port busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cpu_busy <= 1'b0;
         r_aux_busy <= 1'b0;
      end else begin
         if (w_gnt_cpu)      r_cpu_busy <= 1'b1;
         else if (r_cpu_ack) r_cpu_busy <= 1'b0;
         if (w_gnt_aux)      r_aux_busy <= 1'b1;
         else if (r_aux_ack) r_aux_busy <= 1'b0;
      end
   end

   assign bus.cpu_ack  = r_cpu_ack;
   assign bus.cpu_data = r_cpu_data;
   assign bus.aux_ack  = r_aux_ack;
   assign bus.aux_data = r_aux_data;
   assign bus.rom_a    = r_rom_a;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_rom_arbiter                                                       |
// | Self-checking bench: directed vector table, hand sequences for       |
// | reset/starvation, and random traffic against a reference model.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rom_arbiter;
   import rom_arb_pkg::*;

   localparam int AW   = 15;
   localparam int DW   = 8;
   localparam int SMAX = 4;

   logic clk;
   logic rst_n;

   rom_arb_if #(.AW(AW), .DW(DW)) bus ();

   rom_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read ROM model
   always @(posedge clk) bus.rom_dout <= mem[bus.rom_a];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One clock; the bench samples outputs and drives inputs 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          cr;
      logic          ar;
      logic [AW-1:0] ca;
      logic [AW-1:0] aa;
      logic [AW-1:0] exp_rom_a;
      int            cdly;
      int            adly;
      logic [DW-1:0] cdat;
      logic [DW-1:0] adat;
   } vec_t;

   vec_t vt [4];

   // Issue the requests of one vector, hold each until its ack, then drop it
   task automatic run_vec(input vec_t v, input int idx);
      int c_n, a_n, c_d, a_d;
      logic [DW-1:0] c_v, a_v;
      c_n = 0; a_n = 0; c_d = 0; a_d = 0; c_v = '0; a_v = '0;
      bus.cpu_req  = v.cr;
      bus.cpu_addr = v.ca;
      bus.aux_req  = v.ar;
      bus.aux_addr = v.aa;
      for (int d = 1; d <= 8; d++) begin
         tick();
         if (d == 1) chk($sformatf("vec%0d rom_a", idx), 32'(bus.rom_a), 32'(v.exp_rom_a));
         if (bus.cpu_ack) begin c_n++; c_d = d; c_v = bus.cpu_data; bus.cpu_req = 1'b0; end
         if (bus.aux_ack) begin a_n++; a_d = d; a_v = bus.aux_data; bus.aux_req = 1'b0; end
      end
      chk($sformatf("vec%0d cpu ack count", idx), 32'(c_n), v.cr ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d aux ack count", idx), 32'(a_n), v.ar ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d cpu latency", idx), 32'(c_d), 32'(v.cdly));
      chk($sformatf("vec%0d aux latency", idx), 32'(a_d), 32'(v.adly));
      if (v.cr) chk($sformatf("vec%0d cpu data", idx), 32'(c_v), 32'(v.cdat));
      if (v.ar) chk($sformatf("vec%0d aux data", idx), 32'(a_v), 32'(v.adat));
   endtask

   // Scratch state for hand sequences and the reference model
   int            st_aux_start, st_max_wait, st_n_aux, st_n_cpu, n_rst_ack, f_dly;
   logic [DW-1:0] st_ce, st_ae, f_dat;
   logic          m_cpend, m_apend, m_cw, m_aw, m_ce, m_ae, m_gc, m_ga, m_eca, m_eaa;
   int            m_cackc, m_aackc, m_starve;
   logic          m_last_aux;
   logic [DW-1:0] m_cexp, m_aexp, m_cdata, m_adata;
   logic [AW-1:0] m_rom_a;

   initial begin
      rst_n        = 1'b0;
      bus.cpu_req  = 1'b0;
      bus.aux_req  = 1'b0;
      bus.cpu_addr = '0;
      bus.aux_addr = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem[15'h0000] = 8'h21;
      mem[15'h0001] = 8'h0E;
      mem[15'h0007] = 8'hED;
      mem[15'h1234] = 8'hC3;
      mem[15'h7FFE] = 8'h3C;
      mem[15'h7FFF] = 8'h5A;

      //                cr    ar    ca        aa        rom_a     cdly adly cdat   adat
      vt[0] = '{1'b1, 1'b1, 15'h0000, 15'h0001, 15'h0000, 3,   4,   8'h21, 8'h0E};
      vt[1] = '{1'b1, 1'b0, 15'h0007, 15'h0000, 15'h0007, 3,   0,   8'hED, 8'h00};
      vt[2] = '{1'b0, 1'b1, 15'h0000, 15'h7FFF, 15'h7FFF, 0,   3,   8'h00, 8'h5A};
      vt[3] = '{1'b1, 1'b1, 15'h1234, 15'h7FFE, 15'h1234, 3,   4,   8'hC3, 8'h3C};

      // Reset state with both requests idle
      do_reset(3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle cpu_ack",  32'(bus.cpu_ack),  32'd0);
         chk("idle aux_ack",  32'(bus.aux_ack),  32'd0);
         chk("idle cpu_data", 32'(bus.cpu_data), 32'd0);
         chk("idle aux_data", 32'(bus.aux_data), 32'd0);
         chk("idle rom_a",    32'(bus.rom_a),    32'd0);
      end

      // Directed vectors
      for (int i = 0; i < 4; i++) run_vec(vt[i], i);

      // CPU streams a new address every ack while aux keeps requesting
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = AW'($urandom);
      st_ce        = mem[bus.cpu_addr];
      bus.aux_req  = 1'b1;
      bus.aux_addr = AW'($urandom);
      st_ae        = mem[bus.aux_addr];
      st_aux_start = cyc;
      st_max_wait  = 0;
      st_n_aux     = 0;
      st_n_cpu     = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.cpu_ack) begin
            chk("stream cpu data", 32'(bus.cpu_data), 32'(st_ce));
            st_n_cpu++;
            bus.cpu_addr = AW'($urandom);
            st_ce        = mem[bus.cpu_addr];
         end
         if (bus.aux_ack) begin
            chk("stream aux data", 32'(bus.aux_data), 32'(st_ae));
            st_n_aux++;
            if (cyc - st_aux_start > st_max_wait) st_max_wait = cyc - st_aux_start;
            bus.aux_addr = AW'($urandom);
            st_ae        = mem[bus.aux_addr];
            st_aux_start = cyc;
         end
      end
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      chk("stream aux max wait bounded", 32'(st_max_wait <= 7), 32'd1);
      chk("stream aux progress",         32'(st_n_aux >= 4),    32'd1);
      chk("stream cpu progress",         32'(st_n_cpu >= 4),    32'd1);
      repeat (6) tick();

      // Reset with two accesses in flight
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0010;
      bus.aux_req  = 1'b1;
      bus.aux_addr = 15'h0011;
      tick();
      tick();
      rst_n       = 1'b0;
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midreset rom_a", 32'(bus.rom_a), 32'd0);
      n_rst_ack = 0;
      if (bus.cpu_ack || bus.aux_ack) n_rst_ack++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.cpu_ack || bus.aux_ack) n_rst_ack++;
      end
      chk("midreset no ack", 32'(n_rst_ack), 32'd0);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0020;
      f_dly = 0;
      f_dat = '0;
      for (int d = 1; d <= 6; d++) begin
         tick();
         if (bus.cpu_ack) begin f_dly = d; f_dat = bus.cpu_data; bus.cpu_req = 1'b0; end
      end
      chk("postreset cpu latency", 32'(f_dly), 32'd3);
      chk("postreset cpu data",    32'(f_dat), 32'(mem[15'h0020]));

      // Random traffic against the reference model
      do_reset(2);
      m_cpend = 1'b0; m_apend = 1'b0; m_cw = 1'b0; m_aw = 1'b0;
      m_cackc = 0; m_aackc = 0; m_starve = 0; m_last_aux = 1'b1;
      m_cexp = '0; m_aexp = '0; m_cdata = '0; m_adata = '0; m_rom_a = '0;
      for (int t = 0; t < 600; t++) begin
         tick();
         m_eca = m_cpend && (m_cackc == cyc);
         m_eaa = m_apend && (m_aackc == cyc);
         chk("rnd cpu_ack", 32'(bus.cpu_ack), 32'(m_eca));
         chk("rnd aux_ack", 32'(bus.aux_ack), 32'(m_eaa));
         if (m_eca) begin m_cdata = m_cexp; m_cpend = 1'b0; m_cw = 1'b0; end
         if (m_eaa) begin m_adata = m_aexp; m_apend = 1'b0; m_aw = 1'b0; end
         chk("rnd cpu_data", 32'(bus.cpu_data), 32'(m_cdata));
         chk("rnd aux_data", 32'(bus.aux_data), 32'(m_adata));
         chk("rnd rom_a",    32'(bus.rom_a),    32'(m_rom_a));

         // Requesters hold a request until its ack, then may issue a new one at once
         if (!m_cw) begin
            if ($urandom_range(3) != 0) begin
               m_cw = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = AW'($urandom);
            end else bus.cpu_req = 1'b0;
         end
         if (!m_aw) begin
            if ($urandom_range(3) != 0) begin
               m_aw = 1'b1; bus.aux_req = 1'b1; bus.aux_addr = AW'($urandom);
            end else bus.aux_req = 1'b0;
         end

         // Arbitration for the requests presented this cycle
         m_ce = bus.cpu_req && !m_cpend;
         m_ae = bus.aux_req && !m_apend;
         m_gc = 1'b0;
         m_ga = 1'b0;
         if (m_ce && m_ae) begin
`ifdef ROM_ARB_RR_EN
            m_gc = m_last_aux;
            m_ga = !m_last_aux;
`else
            m_ga = (m_starve == SMAX);
            m_gc = !m_ga;
`endif
         end else begin
            m_gc = m_ce;
            m_ga = m_ae;
         end
`ifdef ROM_ARB_RR_EN
         if (m_gc)      m_last_aux = 1'b0;
         else if (m_ga) m_last_aux = 1'b1;
`else
         if (m_ae && !m_ga) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         else               m_starve = 0;
`endif
         if (m_gc) begin
            m_cpend = 1'b1; m_cackc = cyc + ROM_ARB_LAT;
            m_cexp  = mem[bus.cpu_addr]; m_rom_a = bus.cpu_addr;
         end
         if (m_ga) begin
            m_apend = 1'b1; m_aackc = cyc + ROM_ARB_LAT;
            m_aexp  = mem[bus.aux_addr]; m_rom_a = bus.aux_addr;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
